// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, historical rotor wirings and notches,
// and the role codes that select a rotor's stepping behaviour.
package enigma_pkg;

  localparam int N = 26;
  localparam int W = 5;

  localparam int ROLE_FAST   = 0;
  localparam int ROLE_MIDDLE = 1;
  localparam int ROLE_SLOW   = 2;

  localparam int NOTCH_I   = 16;
  localparam int NOTCH_II  = 4;
  localparam int NOTCH_III = 21;
  localparam int NOTCH_IV  = 9;
  localparam int NOTCH_V   = 25;

  // Leftmost letter of the string is entry 0, stored in the lowest W bits.
  function automatic logic [N*W-1:0] wiring_from_letters(input logic [8*N-1:0] letters);
    logic [N*W-1:0] bits;
    logic [7:0]     ch;
    bits = '0;
    for (int i = 0; i < N; i++) begin
      ch = letters[8*(N-1-i) +: 8];
      bits[W*i +: W] = W'(ch - 8'd65);
    end
    return bits;
  endfunction

  localparam logic [N*W-1:0] ROTOR_I   = wiring_from_letters("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
  localparam logic [N*W-1:0] ROTOR_II  = wiring_from_letters("AJDKSIRUXBLHWTMCQGZNPYFVOE");
  localparam logic [N*W-1:0] ROTOR_III = wiring_from_letters("BDFHJLCPRTXVZNYEIWGAKMUSQO");
  localparam logic [N*W-1:0] ROTOR_IV  = wiring_from_letters("ESOVPZJAYQUIRHXLNFTGKDCMWB");
  localparam logic [N*W-1:0] ROTOR_V   = wiring_from_letters("VZBRGITYUPSDNHLXAWMJQOFECK");

endpackage

// File: rtl/enigma_mod_addsub.sv
// Combinational modulo-N add or subtract of two operands already in 0..N-1,
// using one W+1 bit add/sub followed by a single conditional correction.
module enigma_mod_addsub #(
  parameter int N = 26,
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = '0;
    if (sub) begin
      y = diff[W] ? W'(diff + (W+1)'(N)) : diff[W-1:0];
    end else begin
      y = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    end
  end

endmodule

// File: rtl/enigma_rotor_stage.sv
// One Enigma rotor slot: loadable wiring and inverse tables, notch-driven stepping
// with middle-rotor double step, and registered forward and reverse substitution.
module enigma_rotor_stage #(
  parameter int N     = 26,
  parameter int W     = 5,
  parameter int NOTCH = 16,
  parameter int ROLE  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         pos_load,
  input  logic [W-1:0] pos_in,
  input  logic [W-1:0] ring_in,
  input  logic         key,
  input  logic         step_in,
  output logic         step_out,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] fwd_in,
  input  logic [W-1:0] rev_in,
  output logic         out_valid,
  output logic [W-1:0] fwd_out,
  output logic [W-1:0] rev_out,
  output logic         err,
  output logic [W-1:0] pos_out
);
  import enigma_pkg::*;

  logic [W-1:0] fwd_tbl_q [N];
  logic [W-1:0] fwd_tbl_d [N];
  logic [W-1:0] inv_tbl_q [N];
  logic [W-1:0] inv_tbl_d [N];

  logic [W-1:0] pos_q, pos_d;
  logic [W-1:0] ring_q, ring_d;
  logic [W-1:0] fwd_out_q, fwd_out_d;
  logic [W-1:0] rev_out_q, rev_out_d;
  logic         out_valid_q, out_valid_d;
  logic         err_q, err_d;

  logic         at_notch, step, accept, fwd_bad, rev_bad;
  logic [W-1:0] s_fwd, s_rev, fwd_idx, rev_idx;
  logic [W-1:0] fwd_map, rev_map, fwd_res, rev_res;

  assign at_notch = (pos_q == W'(NOTCH));

  // A middle rotor sitting on its notch steps itself on a keypress: the double step.
  always_comb begin
    step = step_in;
    if (ROLE == ROLE_FAST) begin
      step = key;
    end else if (ROLE == ROLE_MIDDLE) begin
      step = step_in | (key & at_notch);
    end
  end

  assign step_out = step & at_notch;

  always_comb begin
    pos_d  = pos_q;
    ring_d = ring_q;
    if (pos_load) begin
      pos_d  = pos_in;
      ring_d = ring_in;
    end else if (step) begin
      pos_d = (pos_q == W'(N-1)) ? '0 : pos_q + W'(1);
    end
  end

  always_comb begin
    fwd_tbl_d = fwd_tbl_q;
    inv_tbl_d = inv_tbl_q;
    if (cfg_we && (cfg_addr < W'(N)) && (cfg_data < W'(N))) begin
      fwd_tbl_d[cfg_addr] = cfg_data;
      inv_tbl_d[cfg_data] = cfg_addr;
    end
  end

  enigma_mod_addsub #(.N(N), .W(W)) u_fwd_offset   (.a(pos_q),   .b(ring_q), .sub(1'b1), .y(s_fwd));
  enigma_mod_addsub #(.N(N), .W(W)) u_fwd_index    (.a(fwd_in),  .b(s_fwd),  .sub(1'b0), .y(fwd_idx));
  enigma_mod_addsub #(.N(N), .W(W)) u_fwd_unoffset (.a(fwd_map), .b(s_fwd),  .sub(1'b1), .y(fwd_res));
  enigma_mod_addsub #(.N(N), .W(W)) u_rev_offset   (.a(pos_q),   .b(ring_q), .sub(1'b1), .y(s_rev));
  enigma_mod_addsub #(.N(N), .W(W)) u_rev_index    (.a(rev_in),  .b(s_rev),  .sub(1'b0), .y(rev_idx));
  enigma_mod_addsub #(.N(N), .W(W)) u_rev_unoffset (.a(rev_map), .b(s_rev),  .sub(1'b1), .y(rev_res));

  // Out-of-range symbols can push the index past the table; those results are discarded anyway.
  always_comb begin
    fwd_map = '0;
    rev_map = '0;
    if (fwd_idx < W'(N)) fwd_map = fwd_tbl_q[fwd_idx];
    if (rev_idx < W'(N)) rev_map = inv_tbl_q[rev_idx];
  end

  assign in_ready = ~cfg_we;
  assign accept   = in_valid & in_ready;
  assign fwd_bad  = (fwd_in >= W'(N));
  assign rev_bad  = (rev_in >= W'(N));

  always_comb begin
    out_valid_d = accept;
    err_d       = 1'b0;
    fwd_out_d   = fwd_out_q;
    rev_out_d   = rev_out_q;
    if (accept) begin
      err_d     = fwd_bad | rev_bad;
      fwd_out_d = fwd_bad ? '0 : fwd_res;
      rev_out_d = rev_bad ? '0 : rev_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        fwd_tbl_q[i] <= W'(i);
        inv_tbl_q[i] <= W'(i);
      end
      pos_q       <= '0;
      ring_q      <= '0;
      fwd_out_q   <= '0;
      rev_out_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fwd_tbl_q   <= fwd_tbl_d;
      inv_tbl_q   <= inv_tbl_d;
      pos_q       <= pos_d;
      ring_q      <= ring_d;
      fwd_out_q   <= fwd_out_d;
      rev_out_q   <= rev_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign fwd_out   = fwd_out_q;
  assign rev_out   = rev_out_q;
  assign err       = err_q;
  assign pos_out   = pos_q;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Exercises fast, middle and slow rotor instances side by side against a
// behavioural Enigma rotor model, with directed historical cases then random traffic.
module tb_enigma_rotor_stage;
  import enigma_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cfg_we, pos_load, key, in_valid;
  logic [W-1:0] cfg_addr, cfg_data, pos_in, ring_in, fwd_in, rev_in;
  logic [NI-1:0] step_in, step_out, in_ready, out_valid, err;
  logic [W-1:0] fwd_out [NI];
  logic [W-1:0] rev_out [NI];
  logic [W-1:0] pos_out [NI];

  enigma_rotor_stage #(.N(N), .W(W), .NOTCH(16), .ROLE(ROLE_FAST)) u_fast (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pos_load(pos_load), .pos_in(pos_in), .ring_in(ring_in), .key(key),
    .step_in(step_in[0]), .step_out(step_out[0]), .in_valid(in_valid), .in_ready(in_ready[0]),
    .fwd_in(fwd_in), .rev_in(rev_in), .out_valid(out_valid[0]), .fwd_out(fwd_out[0]),
    .rev_out(rev_out[0]), .err(err[0]), .pos_out(pos_out[0]));

  enigma_rotor_stage #(.N(N), .W(W), .NOTCH(4), .ROLE(ROLE_MIDDLE)) u_middle (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pos_load(pos_load), .pos_in(pos_in), .ring_in(ring_in), .key(key),
    .step_in(step_in[1]), .step_out(step_out[1]), .in_valid(in_valid), .in_ready(in_ready[1]),
    .fwd_in(fwd_in), .rev_in(rev_in), .out_valid(out_valid[1]), .fwd_out(fwd_out[1]),
    .rev_out(rev_out[1]), .err(err[1]), .pos_out(pos_out[1]));

  enigma_rotor_stage #(.N(N), .W(W), .NOTCH(4), .ROLE(ROLE_SLOW)) u_slow (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pos_load(pos_load), .pos_in(pos_in), .ring_in(ring_in), .key(key),
    .step_in(step_in[2]), .step_out(step_out[2]), .in_valid(in_valid), .in_ready(in_ready[2]),
    .fwd_in(fwd_in), .rev_in(rev_in), .out_valid(out_valid[2]), .fwd_out(fwd_out[2]),
    .rev_out(rev_out[2]), .err(err[2]), .pos_out(pos_out[2]));

  int checks   = 0;
  int failures = 0;

  int m_tbl [N];
  int m_inv [N];
  int m_pos [NI];
  int m_ring [NI];
  int m_fwd [NI];
  int m_rev [NI];
  bit m_vld [NI];
  bit m_err [NI];
  bit step_seen [NI];

  string rotor_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int notchOf(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  // Fast rotor moves on every key; middle moves on a carry or on a key while on its own notch; slow only on a carry.
  function automatic bit rotorSteps(input int i);
    bit on_notch;
    on_notch = (m_pos[i] == notchOf(i));
    case (i)
      0:       return key;
      1:       return step_in[1] || (key && on_notch);
      default: return step_in[2];
    endcase
  endfunction

  function automatic int modN(input int v);
    return ((v % N) + N) % N;
  endfunction

  task automatic modelReset();
    for (int a = 0; a < N; a++) begin
      m_tbl[a] = a;
      m_inv[a] = a;
    end
    for (int i = 0; i < NI; i++) begin
      m_pos[i] = 0; m_ring[i] = 0; m_fwd[i] = 0; m_rev[i] = 0;
      m_vld[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic applyStimulus();
    bit stp [NI];
    bit acc;
    int s, fi, ri;
    #1;
    acc = in_valid && !cfg_we;
    fi  = int'(fwd_in);
    ri  = int'(rev_in);
    for (int i = 0; i < NI; i++) begin
      stp[i]       = rotorSteps(i);
      step_seen[i] = step_out[i];
      checkOutput($sformatf("in_ready[%0d]", i), in_ready[i], !cfg_we);
      checkOutput($sformatf("step_out[%0d]", i), step_out[i], stp[i] && (m_pos[i] == notchOf(i)));
    end
    if (rst) begin
      modelReset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (acc) begin
          s        = modN(m_pos[i] - m_ring[i]);
          m_vld[i] = 1;
          m_err[i] = (fi >= N) || (ri >= N);
          m_fwd[i] = (fi >= N) ? 0 : modN(m_tbl[modN(fi + s)] - s);
          m_rev[i] = (ri >= N) ? 0 : modN(m_inv[modN(ri + s)] - s);
        end else begin
          m_vld[i] = 0;
          m_err[i] = 0;
        end
        if (pos_load) begin
          m_pos[i]  = int'(pos_in);
          m_ring[i] = int'(ring_in);
        end else if (stp[i]) begin
          m_pos[i] = modN(m_pos[i] + 1);
        end
      end
      if (cfg_we && (int'(cfg_addr) < N) && (int'(cfg_data) < N)) begin
        m_tbl[int'(cfg_addr)] = int'(cfg_data);
        m_inv[int'(cfg_data)] = int'(cfg_addr);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("out_valid[%0d]", i), out_valid[i], m_vld[i]);
      checkOutput($sformatf("err[%0d]", i), err[i], m_err[i]);
      checkOutput($sformatf("fwd_out[%0d]", i), fwd_out[i], m_fwd[i]);
      checkOutput($sformatf("rev_out[%0d]", i), rev_out[i], m_rev[i]);
      checkOutput($sformatf("pos_out[%0d]", i), pos_out[i], m_pos[i]);
    end
  endtask

  task automatic idleInputs();
    rst = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; pos_load = 0; pos_in = '0;
    ring_in = '0; key = 0; step_in = '0; in_valid = 0; fwd_in = '0; rev_in = '0;
  endtask

  task automatic loadPosition(input int p, input int r);
    idleInputs();
    pos_load = 1; pos_in = W'(p); ring_in = W'(r);
    applyStimulus();
    pos_load = 0;
  endtask

  task automatic sendSymbols(input int f, input int r);
    idleInputs();
    in_valid = 1; fwd_in = W'(f); rev_in = W'(r);
    applyStimulus();
    in_valid = 0;
  endtask

  initial begin
    int perm [N];
    int j, t;
    modelReset();
    idleInputs();
    rst = 1;
    applyStimulus();
    checkOutput("reset_out_valid", out_valid[0], 0);
    checkOutput("reset_pos", pos_out[0], 0);
    checkOutput("reset_fwd_out", fwd_out[0], 0);
    rst = 0;

    sendSymbols(7, 7);
    checkOutput("identity_fwd", fwd_out[0], 7);
    checkOutput("identity_rev", rev_out[0], 7);
    checkOutput("identity_valid", out_valid[0], 1);

    // Rotor I wiring, with a data beat colliding with the first write.
    for (int a = 0; a < N; a++) begin
      idleInputs();
      cfg_we = 1; cfg_addr = W'(a); cfg_data = W'(rotor_i[a] - 8'd65);
      if (a == 0) begin
        in_valid = 1; fwd_in = W'(3); rev_in = W'(3);
      end
      applyStimulus();
      if (a == 0) checkOutput("cfg_collision_valid", out_valid[0], 0);
    end

    loadPosition(0, 0);
    sendSymbols(0, 4);
    checkOutput("rotor_i_A_to_E", fwd_out[0], 4);
    checkOutput("rotor_i_E_back_A", rev_out[0], 0);

    loadPosition(1, 0);
    sendSymbols(0, 0);
    checkOutput("rotor_i_pos1", fwd_out[0], 9);
    loadPosition(0, 1);
    sendSymbols(0, 0);
    checkOutput("rotor_i_ring1", fwd_out[0], 10);

    loadPosition(16, 0);
    idleInputs(); key = 1; applyStimulus();
    checkOutput("fast_notch_carry", step_seen[0], 1);
    checkOutput("fast_notch_pos", pos_out[0], 17);
    loadPosition(25, 0);
    idleInputs(); key = 1; applyStimulus();
    checkOutput("fast_wrap_carry", step_seen[0], 0);
    checkOutput("fast_wrap_pos", pos_out[0], 0);

    loadPosition(4, 0);
    idleInputs(); key = 1; applyStimulus();
    checkOutput("middle_double_carry", step_seen[1], 1);
    checkOutput("middle_double_pos", pos_out[1], 5);
    checkOutput("slow_no_carry", step_seen[2], 0);
    checkOutput("slow_no_step_pos", pos_out[2], 4);

    idleInputs(); pos_load = 1; pos_in = W'(3); key = 1; applyStimulus();
    checkOutput("load_beats_step", pos_out[0], 3);

    sendSymbols(26, 2);
    checkOutput("range_err", err[0], 1);
    checkOutput("range_fwd_zero", fwd_out[0], 0);

    sendSymbols(5, 5);
    idleInputs(); rst = 1; in_valid = 1; fwd_in = W'(6); rev_in = W'(6);
    applyStimulus();
    checkOutput("reset_drops_result", out_valid[0], 0);

    // Random permutation load followed by mixed random traffic.
    for (int a = 0; a < N; a++) perm[a] = a;
    for (int a = N - 1; a > 0; a--) begin
      j = $urandom_range(0, a);
      t = perm[a]; perm[a] = perm[j]; perm[j] = t;
    end
    for (int a = 0; a < N; a++) begin
      idleInputs();
      cfg_we = 1; cfg_addr = W'(a); cfg_data = W'(perm[a]);
      applyStimulus();
    end

    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      cfg_we   = ($urandom_range(0, 19) == 0);
      cfg_addr = W'($urandom_range(0, 31));
      cfg_data = W'($urandom_range(0, 31));
      pos_load = ($urandom_range(0, 24) == 0);
      pos_in   = W'($urandom_range(0, N - 1));
      ring_in  = W'($urandom_range(0, N - 1));
      key      = 1'($urandom_range(0, 1));
      step_in  = NI'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      fwd_in   = ($urandom_range(0, 15) == 0) ? W'($urandom_range(N, 31)) : W'($urandom_range(0, N - 1));
      rev_in   = ($urandom_range(0, 15) == 0) ? W'($urandom_range(N, 31)) : W'($urandom_range(0, N - 1));
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
